// File: rtl/sdram_if.sv
// SDRAM command/address pin bundle driven by the init controller.
interface sdram_if;
    logic        sdram_clk;
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_dqm;

    modport master (
        output sdram_clk, sdram_cke,
        output sdram_cs_n, sdram_ras_n,
        output sdram_cas_n, sdram_we_n,
        output sdram_bank, sdram_addr,
        output sdram_dqm
    );

    modport slave (
        input sdram_clk, sdram_cke,
        input sdram_cs_n, sdram_ras_n,
        input sdram_cas_n, sdram_we_n,
        input sdram_bank, sdram_addr,
        input sdram_dqm
    );
endinterface

// File: rtl/sdram_init_top.sv
// SDRAM power-up init: wait, PRECHARGE ALL, AUTO REFRESH xN, LOAD MODE,
// then idle on NOP with init_done held high.
module sdram_init_top #(
    parameter int          T_POWER  = 10000,
    parameter int          T_RP     = 2,
    parameter int          T_RFC    = 7,
    parameter int          T_MRD    = 3,
    parameter int          AREF_NUM = 8,
    parameter logic [11:0] MODE_REG = 12'b00_0_00_011_0_111
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    sdram_if.master     sdram,
    inout  wire  [15:0] sdram_dq,
    output logic        init_done
);

    localparam int CNT_W = $clog2(T_POWER + 1);
    localparam int AW    = $clog2(AREF_NUM + 1);

    localparam logic [CNT_W-1:0] C_POWER = CNT_W'(T_POWER - 1);
    localparam logic [CNT_W-1:0] C_RP    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] C_RFC   = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] C_MRD   = CNT_W'(T_MRD - 1);
    localparam logic [AW-1:0]    C_AREF  = AW'(AREF_NUM);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [2:0] {
        S_WAIT,
        S_PRE,
        S_TRP,
        S_AREF,
        S_TRF,
        S_MRS,
        S_TMRD,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [AW-1:0]    r_aref;
    logic [AW-1:0]    w_aref_nxt;
    logic [3:0]       r_cmd;
    logic [3:0]       w_cmd;
    logic [11:0]      r_addr;
    logic [11:0]      w_addr;
    logic [1:0]       r_bank;
    logic [1:0]       w_bank;
    logic             r_done;
    logic             w_done;

    // State and counters describe the cycle about to be issued; the
    // command registers capture it on the same edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_aref  <= '0;
            r_cmd   <= CMD_NOP;
            r_addr  <= 12'hFFF;
            r_bank  <= 2'b11;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_aref  <= w_aref_nxt;
            r_cmd   <= w_cmd;
            r_addr  <= w_addr;
            r_bank  <= w_bank;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_aref_nxt  = r_aref;
        w_cmd       = CMD_NOP;
        w_addr      = 12'hFFF;
        w_bank      = 2'b11;
        w_done      = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                if (r_cnt == C_POWER) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRE: begin
                w_cmd       = CMD_PRE;
                w_addr      = 12'h400;
                w_state_nxt = S_TRP;
                w_cnt_nxt   = '0;
            end
            S_TRP: begin
                if (r_cnt == C_RP) begin
                    w_state_nxt = S_AREF;
                    w_cnt_nxt   = '0;
                end
            end
            S_AREF: begin
                w_cmd = CMD_AREF;
                if (r_aref < C_AREF)
                    w_aref_nxt = r_aref + 1'b1;
                w_state_nxt = S_TRF;
                w_cnt_nxt   = '0;
            end
            S_TRF: begin
                if (r_cnt == C_RFC) begin
                    w_state_nxt = (r_aref < C_AREF) ? S_AREF : S_MRS;
                    w_cnt_nxt   = '0;
                end
            end
            S_MRS: begin
                w_cmd       = CMD_LMR;
                w_addr      = MODE_REG;
                w_bank      = 2'b00;
                w_state_nxt = S_TMRD;
                w_cnt_nxt   = '0;
            end
            S_TMRD: begin
                if (r_cnt == C_MRD) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                w_cnt_nxt = '0;
                w_done    = 1'b1;
            end
        endcase
    end

    assign sdram.sdram_clk   = ~sys_clk;
    assign sdram.sdram_cke   = 1'b1;
    assign sdram.sdram_dqm   = 2'b00;
    assign sdram.sdram_cs_n  = r_cmd[3];
    assign sdram.sdram_ras_n = r_cmd[2];
    assign sdram.sdram_cas_n = r_cmd[1];
    assign sdram.sdram_we_n  = r_cmd[0];
    assign sdram.sdram_addr  = r_addr;
    assign sdram.sdram_bank  = r_bank;
    assign sdram_dq          = 'z;
    assign init_done         = r_done;

endmodule

// File: tb/tb_sdram_init_top.sv
// Directed bench for sdram_init_top: command timeline, vectors, mid-run reset.
module tb_sdram_init_top;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMR  = 4'b0000;
    localparam int         NV   = 14;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic        done;
        bit          ca;
        bit          cb;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        done;
    wire  [15:0] dq;
    int          n_pass;
    int          n_total;
    vec_t        vec [NV];

    sdram_if sd ();

    sdram_init_top dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .sdram     (sd.master),
        .sdram_dq  (dq),
        .init_done (done)
    );

    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup pu (dq[g]);
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    wire [3:0] cmd = {sd.sdram_cs_n, sd.sdram_ras_n,
                      sd.sdram_cas_n, sd.sdram_we_n};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [3:0] exp_cmd(input int c);
        if (c == 10000) return PRE;
        if (c >= 10003 && c <= 10059 && ((c - 10003) % 8) == 0) return AREF;
        if (c == 10067) return LMR;
        return NOP;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd"},  32'(cmd),           32'(NOP));
        chk({tag, "_addr"}, 32'(sd.sdram_addr), 32'h0000_0FFF);
        chk({tag, "_bank"}, 32'(sd.sdram_bank), 32'd3);
        chk({tag, "_done"}, 32'(done),          32'd0);
    endtask

    // Cycle 0 is the first rising edge after reset release; sampled 5 ns later.
    task automatic run(input int last, input string tag);
        int vi       = 0;
        int bad_cmd  = 0;
        int bad_done = 0;
        int bad_stat = 0;
        int arefs    = 0;
        int exp_ar   = 0;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #5;
            if (cmd !== exp_cmd(c)) bad_cmd++;
            if (exp_cmd(c) == AREF) exp_ar++;
            if (cmd === AREF) arefs++;
            if (done !== (c >= 10071)) bad_done++;
            if (sd.sdram_cke !== 1'b1 || sd.sdram_dqm !== 2'b00 ||
                dq !== 16'hFFFF || sd.sdram_clk !== 1'b0)
                bad_stat++;
            if (vi < NV && vec[vi].cyc == c) begin
                chk($sformatf("%s_c%0d_cmd", tag, c), 32'(cmd), 32'(vec[vi].cmd));
                chk($sformatf("%s_c%0d_done", tag, c), 32'(done), 32'(vec[vi].done));
                if (vec[vi].ca)
                    chk($sformatf("%s_c%0d_addr", tag, c),
                        32'(sd.sdram_addr), 32'(vec[vi].addr));
                if (vec[vi].cb)
                    chk($sformatf("%s_c%0d_bank", tag, c),
                        32'(sd.sdram_bank), 32'(vec[vi].bank));
                vi++;
            end
        end
        chk({tag, "_timeline"},   32'(bad_cmd),  32'd0);
        chk({tag, "_aref_count"}, 32'(arefs),    32'(exp_ar));
        chk({tag, "_done_track"}, 32'(bad_done), 32'd0);
        chk({tag, "_static_pins"}, 32'(bad_stat), 32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        vec[0]  = '{0,     NOP,  12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{9999,  NOP,  12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{10000, PRE,  12'h400, 2'b11, 1'b0, 1'b1, 1'b1};
        vec[3]  = '{10001, NOP,  12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{10002, NOP,  12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{10003, AREF, 12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{10010, NOP,  12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{10011, AREF, 12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{10059, AREF, 12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{10066, NOP,  12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[10] = '{10067, LMR,  12'h037, 2'b00, 1'b0, 1'b1, 1'b1};
        vec[11] = '{10070, NOP,  12'hFFF, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[12] = '{10071, NOP,  12'hFFF, 2'b11, 1'b1, 1'b1, 1'b0};
        vec[13] = '{11071, NOP,  12'hFFF, 2'b11, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        #50;
        chk_reset_vals("por");
        chk("por_cke", 32'(sd.sdram_cke), 32'd1);
        chk("por_dqm", 32'(sd.sdram_dqm), 32'd0);
        chk("por_dq",  32'(dq),           32'h0000_FFFF);
        #50;
        @(negedge clk);
        rst = 1'b0;
        run(11071, "run1");

        // Mode register decode: CAS latency and burst length fields.
        begin
            logic [11:0] mr;
            mr = vec[10].addr;
            chk("mode_cl", 32'(mr[6:4]), 32'd3);
            chk("mode_bl", 32'(mr[2:0]), 32'd7);
        end

        // Interrupt mid-refresh: cycle 10035 carries the fifth AUTO REFRESH.
        @(negedge clk);
        rst = 1'b1;
        #100;
        @(negedge clk);
        rst = 1'b0;
        run(10035, "pre_int");
        chk("int_aref_before", 32'(cmd), 32'(AREF));
        rst = 1'b1;
        #1;
        chk_reset_vals("int");
        #100;
        @(negedge clk);
        rst = 1'b0;
        run(10100, "run2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
